// File: rtl/c16_sound.sv
// c16_sound -- four-channel tone/noise sound generator.
//
// Takes CPU register stores on the sound write port and produces a mixed
// unsigned PCM sample stream at a fixed rate.
//
// Each channel has four registers, selected by w_param:
//   0 = period
//   1 = volume
//   2 = length (0 = play forever)
//   3 = control (bit0 enable, bit1 noise)
//
// Each channel runs either a square-wave oscillator or an LFSR noise
// oscillator. A length counter can stop the channel automatically. The four
// channel outputs are summed into one sample.
//
// Parameters:
//   TICK_DIV   : clocks per oscillator tick
//   ENV_DIV    : clocks per length-counter tick
//   SAMPLE_DIV : clocks per output sample
//
// Ports:
//   clk          : system clock
//   resetn       : asynchronous reset, active-low
//   snd_wen      : one-cycle register write strobe
//   w_param[1:0] : register select
//   w_index[10:0]: channel select; only [1:0] is used
//   w_val[15:0]  : write data
//   sample_out   : latched mixed sample, unsigned
//   sample_valid : one-cycle strobe when sample_out updates
//   active[3:0]  : per-channel running status
module c16_sound #(
    parameter int TICK_DIV   = 50,
    parameter int ENV_DIV    = 50000,
    parameter int SAMPLE_DIV = 1042
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        snd_wen,
    input  logic [1:0]  w_param,
    input  logic [10:0] w_index,
    input  logic [15:0] w_val,
    output logic [9:0]  sample_out,
    output logic        sample_valid,
    output logic [3:0]  active
);

    localparam int TICK_W = $clog2(TICK_DIV   > 1 ? TICK_DIV   : 2);
    localparam int ENV_W  = $clog2(ENV_DIV    > 1 ? ENV_DIV    : 2);
    localparam int SAMP_W = $clog2(SAMPLE_DIV > 1 ? SAMPLE_DIV : 2);

    localparam logic [1:0] P_PERIOD = 2'd0;
    localparam logic [1:0] P_VOL    = 2'd1;
    localparam logic [1:0] P_LEN    = 2'd2;
    localparam logic [1:0] P_CTRL   = 2'd3;

    // Upper channel-select bits are reserved.
    logic unused_index;
    assign unused_index = ^w_index[10:2];

    // ------------------------------------------------------------------
    // Free-running prescalers.
    // Each counts 0..DIV-1 and pulses while sitting at DIV-1.
    // ------------------------------------------------------------------
    logic [TICK_W-1:0] tick_cnt_reg;
    logic [ENV_W-1:0]  env_cnt_reg;
    logic [SAMP_W-1:0] samp_cnt_reg;
    logic              tick_pulse;
    logic              env_pulse;
    logic              samp_pulse;

    assign tick_pulse = (tick_cnt_reg == TICK_W'(TICK_DIV - 1));
    assign env_pulse  = (env_cnt_reg  == ENV_W'(ENV_DIV - 1));
    assign samp_pulse = (samp_cnt_reg == SAMP_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tick_cnt_reg <= '0;
            env_cnt_reg  <= '0;
            samp_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_pulse ? '0 : tick_cnt_reg + 1'b1;
            env_cnt_reg  <= env_pulse  ? '0 : env_cnt_reg  + 1'b1;
            samp_cnt_reg <= samp_pulse ? '0 : samp_cnt_reg + 1'b1;
        end
    end

    // Per-channel mixer contribution (0 when silent).
    logic [3:0][7:0] term;

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
        logic [15:0] period_reg;
        logic [7:0]  vol_reg;
        logic [15:0] len_reg;
        logic [15:0] phase_ctr_reg;
        logic [15:0] len_ctr_reg;
        logic        noise_reg;
        logic        level_reg;
        logic        active_reg;
        logic [14:0] lfsr_reg;
        logic [14:0] lfsr_next;
        logic        ch_sel;
        logic        restart;

        assign ch_sel    = snd_wen && (w_index[1:0] == 2'(gi));
        assign restart   = ch_sel && (w_param == P_CTRL);
        assign lfsr_next = {lfsr_reg[13:0], lfsr_reg[14] ^ lfsr_reg[13]};

        // Plain register writes; these never disturb a running tone.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                period_reg <= '0;
                vol_reg    <= '0;
                len_reg    <= '0;
            end else if (ch_sel) begin
                if (w_param == P_PERIOD) begin
                    period_reg <= w_val;
                end
                if (w_param == P_VOL) begin
                    vol_reg <= w_val[7:0];
                end
                if (w_param == P_LEN) begin
                    len_reg <= w_val;
                end
            end
        end

        // Oscillator and length counter.
        // A control write restarts the channel and takes priority over any
        // tick, env pulse or length expiry in the same cycle.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                active_reg    <= 1'b0;
                noise_reg     <= 1'b0;
                phase_ctr_reg <= '0;
                len_ctr_reg   <= '0;
                level_reg     <= 1'b1;
                lfsr_reg      <= 15'h7FFF;
            end else if (restart) begin
                active_reg    <= w_val[0];
                noise_reg     <= w_val[1];
                phase_ctr_reg <= period_reg;
                len_ctr_reg   <= len_reg;
                level_reg     <= 1'b1;
                lfsr_reg      <= 15'h7FFF;
            end else if (active_reg) begin
                if (tick_pulse) begin
                    if (phase_ctr_reg == '0) begin
                        phase_ctr_reg <= period_reg;
                        if (noise_reg) begin
                            lfsr_reg  <= lfsr_next;
                            level_reg <= lfsr_next[0];
                        end else begin
                            level_reg <= ~level_reg;
                        end
                    end else begin
                        phase_ctr_reg <= phase_ctr_reg - 1'b1;
                    end
                end
                // len_ctr holds the length latched at restart.
                // Zero there means "infinite", so it never counts.
                if (env_pulse && (len_ctr_reg != '0)) begin
                    len_ctr_reg <= len_ctr_reg - 1'b1;
                    if (len_ctr_reg == 16'd1) begin
                        active_reg <= 1'b0;
                    end
                end
            end
        end

        assign active[gi] = active_reg;
        assign term[gi]   = (active_reg && level_reg) ? vol_reg : 8'd0;
    end

    // ------------------------------------------------------------------
    // Mixer and output latch
    // ------------------------------------------------------------------
    logic [9:0] mix_next;
    logic [9:0] mix_reg;

    // Four 8-bit terms cannot exceed 10 bits (max 0x3FC).
    always_comb begin
        mix_next = 10'(term[0]) + 10'(term[1]) + 10'(term[2]) + 10'(term[3]);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mix_reg      <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            mix_reg      <= mix_next;
            sample_valid <= samp_pulse;
            if (samp_pulse) begin
                sample_out <= mix_reg;
            end
        end
    end

endmodule

// File: tb/tb_c16_sound.sv
module tb_c16_sound;

    localparam int TD = 2;
    localparam int ED = 10;
    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        snd_wen = 1'b0;
    logic [1:0]  w_param = '0;
    logic [10:0] w_index = '0;
    logic [15:0] w_val = '0;
    logic [9:0]  sample_out;
    logic        sample_valid;
    logic [3:0]  active;

    int checks = 0;
    int failures = 0;

    c16_sound #(.TICK_DIV(TD), .ENV_DIV(ED), .SAMPLE_DIV(SD)) dut (
        .clk(clk), .resetn(resetn), .snd_wen(snd_wen), .w_param(w_param),
        .w_index(w_index), .w_val(w_val), .sample_out(sample_out),
        .sample_valid(sample_valid), .active(active)
    );

    initial forever #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model.
    // Tracks, per channel, how many ticks and env pulses have elapsed since
    // the last restart. The waveform level is derived from that count: one
    // waveform step per (period+1) ticks.
    // ------------------------------------------------------------------
    logic [3:0] m_act;
    bit   m_noise [4];
    int   m_ticks [4];
    int   m_envs [4];
    int   m_per [4];
    int   m_len [4];
    int   m_per_reg [4];
    int   m_len_reg [4];
    int   m_vol [4];
    int   exp_mix;
    int   exp_sample;
    bit   exp_valid;

    function automatic bit model_level(int ch);
        int steps;
        logic [14:0] l;
        steps = m_ticks[ch] / (m_per[ch] + 1);
        if (!m_noise[ch]) return (steps % 2) == 0;
        if (steps == 0) return 1'b1;
        l = 15'h7FFF;
        for (int i = 0; i < steps; i++) l = {l[13:0], l[14] ^ l[13]};
        return l[0];
    endfunction

    function automatic int model_mix();
        int s = 0;
        for (int ch = 0; ch < 4; ch++)
            if (m_act[ch] && model_level(ch)) s += m_vol[ch];
        return s;
    endfunction

    initial begin : model
        int  cyc;
        bit  tk;
        bit  ev;
        bit  sp;
        int  nm;
        cyc = 0;
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                cyc = 0; exp_mix = 0; exp_sample = 0; exp_valid = 0; m_act = '0;
                for (int ch = 0; ch < 4; ch++) begin
                    m_noise[ch] = 0; m_ticks[ch] = 0; m_envs[ch] = 0; m_per[ch] = 0;
                    m_len[ch] = 0; m_per_reg[ch] = 0; m_len_reg[ch] = 0; m_vol[ch] = 0;
                end
            end else begin
                tk = (cyc % TD) == TD - 1;
                ev = (cyc % ED) == ED - 1;
                sp = (cyc % SD) == SD - 1;
                nm = model_mix();
                exp_valid = sp;
                if (sp) exp_sample = exp_mix;
                exp_mix = nm;
                for (int ch = 0; ch < 4; ch++) begin
                    if (snd_wen && int'(w_index[1:0]) == ch && w_param == 2'd3) begin
                        m_act[ch] = w_val[0]; m_noise[ch] = w_val[1];
                        m_ticks[ch] = 0; m_envs[ch] = 0;
                        m_per[ch] = m_per_reg[ch]; m_len[ch] = m_len_reg[ch];
                    end else begin
                        if (m_act[ch]) begin
                            if (tk) m_ticks[ch]++;
                            if (ev && m_len[ch] != 0) begin
                                m_envs[ch]++;
                                if (m_envs[ch] == m_len[ch]) m_act[ch] = 1'b0;
                            end
                        end
                        if (snd_wen && int'(w_index[1:0]) == ch) begin
                            if (w_param == 2'd0) m_per_reg[ch] = int'(w_val);
                            if (w_param == 2'd1) m_vol[ch] = int'(w_val[7:0]);
                            if (w_param == 2'd2) m_len_reg[ch] = int'(w_val);
                        end
                    end
                end
                cyc++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (drive only, no checking)
    // ------------------------------------------------------------------
    task automatic do_reset();
        resetn = 1'b0;
        snd_wen = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // Back-to-back calls give writes on consecutive cycles.
    task automatic wr(input logic [1:0] p, input int ch, input logic [15:0] v);
        @(negedge clk);
        snd_wen = 1'b1;
        w_param = p;
        w_index = {9'($urandom), 2'(ch)};
        w_val = v;
    endtask

    task automatic idle();
        @(negedge clk);
        snd_wen = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        int pulses = 0;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if (sample_out !== 10'd0 || active !== 4'd0) begin
                failures++;
                $display("FAIL reset_idle: cyc %0d sample_out=%0h active=%0h required 0/0", i, sample_out, active);
            end
            checks++;
            if (sample_valid !== ((i % SD) == SD - 1)) begin
                failures++;
                $display("FAIL reset_valid: cyc %0d got %0b expected %0b", i, sample_valid, (i % SD) == SD - 1);
            end
            if (sample_valid) pulses++;
        end
        checks++;
        if (pulses != 100 / SD) begin
            failures++;
            $display("FAIL reset_pulse_count: got %0d expected %0d", pulses, 100 / SD);
        end
        $display("test_reset done: %0d valid pulses", pulses);
    endtask

    task automatic test_square();
        int changes = 0;
        int last_t = 0;
        logic [9:0] prev = '0;
        do_reset();
        wr(2'd0, 0, 16'd3);
        wr(2'd1, 0, 16'h40);
        wr(2'd3, 0, 16'h1);
        idle();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            checks++;
            if (active !== 4'b0001) begin
                failures++;
                $display("FAIL square_active: got %b expected 0001", active);
            end
            checks++;
            if (dut.mix_reg !== 10'(exp_mix) || (dut.mix_reg !== 10'h040 && dut.mix_reg !== 10'h000)) begin
                failures++;
                $display("FAIL square_mix: cyc %0d got %0h expected %0h", i, dut.mix_reg, exp_mix);
            end
            if (dut.mix_reg !== prev) begin
                changes++;
                if (changes >= 3) begin
                    checks++;
                    if (i - last_t != 8) begin
                        failures++;
                        $display("FAIL square_halfperiod: got %0d clocks expected 8", i - last_t);
                    end
                end
                last_t = i;
                prev = dut.mix_reg;
            end
        end
        checks++;
        if (changes < 6) begin
            failures++;
            $display("FAIL square_toggles: got %0d changes expected >= 6", changes);
        end
        $display("test_square done: %0d mix changes", changes);
    endtask

    task automatic test_full_mix();
        bit seen = 0;
        do_reset();
        for (int ch = 0; ch < 4; ch++) begin
            wr(2'd1, ch, 16'h00FF);
            wr(2'd0, ch, 16'hFFFF);
            wr(2'd3, ch, 16'h0001);
        end
        idle();
        @(negedge clk);
        checks++;
        if (dut.mix_reg !== 10'h3FC || active !== 4'hF) begin
            failures++;
            $display("FAIL full_mix: got mix=%0h active=%0h expected 3fc/f", dut.mix_reg, active);
        end
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (sample_valid) begin
                seen = 1;
                checks++;
                if (sample_out !== 10'h3FC) begin
                    failures++;
                    $display("FAIL full_sample: got %0h expected 3fc", sample_out);
                end
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL full_sample_timeout: got no sample_valid expected one within 10 clocks");
        end
        $display("test_full_mix done");
    endtask

    task automatic test_length();
        do_reset();
        wr(2'd1, 1, 16'h10);
        wr(2'd2, 1, 16'd2);
        for (int r = 0; r < 2; r++) begin
            int stop_k = -1;
            wr(2'd3, 1, 16'h1);
            idle();
            checks++;
            if (active !== 4'b0010) begin
                failures++;
                $display("FAIL len_start: round %0d got %b expected 0010", r, active);
            end
            for (int k = 1; k <= 24; k++) begin
                @(negedge clk);
                checks++;
                if (active !== m_act || dut.mix_reg !== 10'(exp_mix)) begin
                    failures++;
                    $display("FAIL len_track: round %0d k %0d active=%b/%b mix=%0h/%0h", r, k, active, m_act, dut.mix_reg, exp_mix);
                end
                if (stop_k < 0 && !active[1]) stop_k = k;
            end
            checks++;
            if (stop_k < 1 || stop_k > 20 || dut.mix_reg !== 10'd0) begin
                failures++;
                $display("FAIL len_stop: round %0d stopped at %0d mix=%0h required 1..20 and 0", r, stop_k, dut.mix_reg);
            end
            $display("test_length round %0d: stopped %0d clocks after write", r, stop_k);
        end
    endtask

    task automatic test_noise();
        do_reset();
        wr(2'd0, 2, 16'd0);
        wr(2'd1, 2, 16'h1);
        wr(2'd3, 2, 16'h3);
        idle();
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            checks++;
            if (active !== 4'b0100 || dut.mix_reg !== 10'(exp_mix)) begin
                failures++;
                $display("FAIL noise_track: k %0d active=%b mix=%0h expected 0100/%0h", k, active, dut.mix_reg, exp_mix);
            end
            if (k == 1 || k == 8) begin
                checks++;
                if (dut.mix_reg !== ((k == 1) ? 10'd1 : 10'd0)) begin
                    failures++;
                    $display("FAIL noise_level: k %0d got %0h expected %0h", k, dut.mix_reg, (k == 1) ? 1 : 0);
                end
            end
        end
        $display("test_noise done");
    endtask

    task automatic test_async_reset();
        do_reset();
        wr(2'd0, 0, 16'd3);
        wr(2'd1, 0, 16'h40);
        wr(2'd3, 0, 16'h1);
        idle();
        repeat (6) @(negedge clk);
        checks++;
        if (active !== 4'b0001 || sample_out !== 10'h040) begin
            failures++;
            $display("FAIL areset_pre: active=%b sample_out=%0h expected 0001/40", active, sample_out);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (active !== 4'd0 || sample_out !== 10'd0 || sample_valid !== 1'b0 || dut.mix_reg !== 10'd0) begin
            failures++;
            $display("FAIL areset_immediate: active=%b sample_out=%0h valid=%0b mix=%0h expected all 0", active, sample_out, sample_valid, dut.mix_reg);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            checks++;
            if (active !== 4'd0 || sample_out !== 10'd0 || dut.mix_reg !== 10'd0) begin
                failures++;
                $display("FAIL areset_silent: cyc %0d active=%b sample_out=%0h expected 0", i, active, sample_out);
            end
        end
        $display("test_async_reset done");
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int r = 0; r < 10; r++) begin
            int ch = int'($urandom_range(0, 3));
            logic [15:0] ctl = {14'd0, 1'($urandom), 1'($urandom_range(0, 3) != 0)};
            wr(2'd3, ch, 16'h0);
            wr(2'd0, ch, 16'($urandom_range(0, 5)));
            wr(2'd1, ch, 16'($urandom_range(0, 255)));
            wr(2'd2, ch, 16'($urandom_range(0, 3)));
            wr(2'd3, ch, ctl);
            idle();
            for (int i = 0; i < int'($urandom_range(30, 70)); i++) begin
                @(negedge clk);
                checks++;
                if (active !== m_act || dut.mix_reg !== 10'(exp_mix) ||
                    sample_valid !== exp_valid || sample_out !== 10'(exp_sample)) begin
                    failures++;
                    $display("FAIL random_track: round %0d cyc %0d active=%b/%b mix=%0h/%0h valid=%0b/%0b out=%0h/%0h",
                             r, i, active, m_act, dut.mix_reg, exp_mix, sample_valid, exp_valid, sample_out, exp_sample);
                end
            end
            $display("test_back_to_back round %0d: ch %0d ctrl %0h active %b", r, ch, ctl, active);
        end
    endtask

    initial begin
        test_reset();
        test_square();
        test_full_mix();
        test_length();
        test_noise();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
